// File: rtl/milano_pkg.sv
// Shared definitions for the data memory controller.
// Holds the LSU access-type encoding, the controller FSM state enum and
// small helpers that turn an LSU access into bus lane enables and lane data.
//   lsu_type[1:0] : 00 word, 01 half, 10 byte, 11 reserved
//   lsu_type[2]   : 1 = zero-extend loads, 0 = sign-extend loads
package milano_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int TYPE_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    // An access is legal when it is naturally aligned for its size and the
    // size code is not the reserved one.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SIZE_WORD: ok = (offset == 2'b00);
            SIZE_HALF: ok = (offset[0] == 1'b0);
            SIZE_BYTE: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_WORD: be = 4'b1111;
            SIZE_HALF: be = 4'b0011 << offset;
            SIZE_BYTE: be = 4'b0001 << offset;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is replicated across all lanes so the byte enables alone
    // pick the lane written by memory.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_HALF: d = {2{wdata[15:0]}};
            SIZE_BYTE: d = {4{wdata[7:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and extension (purely combinational).
// Ports:
//   rdata_i  [31:0] raw word returned by memory
//   offset_i [1:0]  byte offset of the access inside the word
//   type_i   [2:0]  access type (size in [1:0], unsigned flag in [2])
//   data_o   [31:0] right-aligned, sign- or zero-extended load result
module load_extend
    import milano_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  type_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_ext;

    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        // Halfwords are aligned, so only offset bit 1 selects the lane.
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_ext  = ~type_i[TYPE_UNSIGNED_BIT];

        case (type_i[1:0])
            SIZE_BYTE: data_o = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: data_o = {{16{sign_ext & half_lane[15]}}, half_lane};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller between the LSU and a req/gnt/rvalid data bus.
// Accepts one access at a time, checks alignment, drives registered bus
// signals, waits for grant and response, and returns extended load data.
// A watchdog aborts a transaction that waits too long.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   lsu_req_i/we_i/type_i        LSU request, store flag, access type
//   lsu_addr_i, lsu_wdata_i      byte address, right-aligned store data
//   lsu_stall_o                  stall while a request is not done
//   lsu_rvalid_o, lsu_rdata_o    completion pulse and load data
//   lsu_err_o                    error pulse (misaligned, reserved, timeout)
//   data_*                       memory bus (all outputs registered)
module data_mem_ctrl
    import milano_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_type_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic [3:0]  data_be_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  offset_q, offset_d;
    logic [2:0]  type_q, type_d;
    logic        data_req_q, data_req_d;
    logic        data_we_q, data_we_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [3:0]  data_be_q, data_be_d;
    logic        lsu_rvalid_q, lsu_rvalid_d;
    logic        lsu_err_q, lsu_err_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;

    logic        done;
    logic [31:0] cnt_inc;
    logic [31:0] load_data;

    load_extend u_load_extend (
        .rdata_i  (data_rdata_i),
        .offset_i (offset_q),
        .type_i   (type_q),
        .data_o   (load_data)
    );

    always_comb begin
        done    = lsu_rvalid_q | lsu_err_q;
        cnt_inc = cnt_q + 32'd1;

        state_d      = state_q;
        cnt_d        = cnt_q;
        offset_d     = offset_q;
        type_d       = type_q;
        data_req_d   = data_req_q;
        data_we_d    = data_we_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_be_d    = data_be_q;
        lsu_rvalid_d = 1'b0;
        lsu_err_d    = 1'b0;
        lsu_rdata_d  = 32'd0;

        case (state_q)
            ST_IDLE: begin
                // The done cycle belongs to the previous access, so a request
                // still high then is not taken as a new one.
                if (lsu_req_i && !done) begin
                    if (access_legal(lsu_type_i[1:0], lsu_addr_i[1:0])) begin
                        state_d      = ST_REQ;
                        cnt_d        = 32'd0;
                        offset_d     = lsu_addr_i[1:0];
                        type_d       = lsu_type_i;
                        data_req_d   = 1'b1;
                        data_we_d    = lsu_we_i;
                        data_addr_d  = {lsu_addr_i[31:2], 2'b00};
                        data_be_d    = byte_enable(lsu_type_i[1:0], lsu_addr_i[1:0]);
                        data_wdata_d = store_data(lsu_type_i[1:0], lsu_wdata_i);
                    end else begin
                        lsu_err_d = 1'b1;
                    end
                end
            end
            ST_REQ, ST_WAIT_RSP: begin
                cnt_d = cnt_inc;
                // The watchdog wins over a grant or response arriving in the
                // same cycle, so an access never exceeds its cycle budget.
                if (cnt_inc == TIMEOUT_LIMIT) begin
                    state_d    = ST_IDLE;
                    data_req_d = 1'b0;
                    lsu_err_d  = 1'b1;
                end else if (state_q == ST_REQ) begin
                    if (data_gnt_i) begin
                        state_d    = ST_WAIT_RSP;
                        data_req_d = 1'b0;
                    end
                end else if (data_rvalid_i) begin
                    state_d      = ST_IDLE;
                    lsu_rvalid_d = 1'b1;
                    lsu_rdata_d  = data_we_q ? 32'd0 : load_data;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                data_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            offset_q     <= 2'd0;
            type_q       <= 3'd0;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            data_be_q    <= 4'd0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            offset_q     <= offset_d;
            type_q       <= type_d;
            data_req_q   <= data_req_d;
            data_we_q    <= data_we_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_be_q    <= data_be_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_err_q    <= lsu_err_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign lsu_stall_o  = lsu_req_i & ~done;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign lsu_err_o    = lsu_err_q;
    assign data_req_o   = data_req_q;
    assign data_we_o    = data_we_q;
    assign data_addr_o  = data_addr_q;
    assign data_wdata_o = data_wdata_q;
    assign data_be_o    = data_be_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed scenarios plus randomized accesses,
// each checked against a transaction-level model of alignment, lane mapping,
// load extension and grant/response/timeout timing.
module tb_data_mem_ctrl;

    localparam int MAIN_TO = 16;
    localparam int SHORT_TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_type_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    logic        lsu_stall_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;

    logic        t4_stall, t4_rvalid, t4_err, t4_req, t4_we;
    logic [31:0] t4_rdata, t4_addr, t4_wdata;
    logic [3:0]  t4_be;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(.TIMEOUT_CYCLES(MAIN_TO)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    data_mem_ctrl #(.TIMEOUT_CYCLES(SHORT_TO)) u_dut_t4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(t4_stall), .lsu_rvalid_o(t4_rvalid),
        .lsu_rdata_o(t4_rdata), .lsu_err_o(t4_err),
        .data_req_o(t4_req), .data_we_o(t4_we), .data_addr_o(t4_addr),
        .data_wdata_o(t4_wdata), .data_be_o(t4_be),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference rules for a single access, written from the access semantics.
    function automatic logic exp_legal(input logic [2:0] t, input logic [31:0] a);
        if (t[1:0] == 2'b11) return 1'b0;
        if (t[1:0] == 2'b00) return (a % 4) == 0;
        if (t[1:0] == 2'b01) return (a % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] t, input logic [31:0] a);
        if (t[1:0] == 2'b00) return 4'hF;
        if (t[1:0] == 2'b01) return 4'(3 << (a % 4));
        return 4'(1 << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] w);
        if (t[1:0] == 2'b01) return {w[15:0], w[15:0]};
        if (t[1:0] == 2'b10) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] mem);
        logic [31:0] v;
        v = mem >> (8 * (a % 4));
        if (t[1:0] == 2'b10) begin
            v = v & 32'h0000_00FF;
            if (!t[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (t[1:0] == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (!t[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One LSU access against the main controller. The bench memory grants in
    // REQ-cycle g and responds r cycles after the grant cycle. Cycle index 0 is
    // the first cycle after acceptance.
    task automatic apply_stimulus(input logic we, input logic [2:0] t, input logic [31:0] a,
                                  input logic [31:0] wd, input int g, input int r,
                                  input logic [31:0] mem, input logic hold);
        logic legal, ok;
        int   done_idx, req_last;
        legal = exp_legal(t, a);
        if (!legal) begin
            ok = 1'b0; done_idx = 0; req_last = -1;
        end else if (g + 1 + r <= MAIN_TO - 2) begin
            ok = 1'b1; done_idx = g + 2 + r; req_last = g;
        end else begin
            ok = 1'b0; done_idx = MAIN_TO; req_last = (g < MAIN_TO - 1) ? g : MAIN_TO - 1;
        end

        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = t; lsu_addr_i = a; lsu_wdata_i = wd;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = mem;
        #1;
        check_output("stall_on_request", 32'(lsu_stall_o), 32'd1);

        for (int i = 0; i <= done_idx; i++) begin
            @(negedge clk_i);
            check_output("data_req", 32'(data_req_o), 32'(i <= req_last));
            if (i == 0 && legal) begin
                check_output("data_addr", data_addr_o, {a[31:2], 2'b00});
                check_output("data_be", 32'(data_be_o), 32'(exp_be(t, a)));
                check_output("data_we", 32'(data_we_o), 32'(we));
                if (we) check_output("data_wdata", data_wdata_o, exp_wdata(t, wd));
            end
            check_output("lsu_rvalid", 32'(lsu_rvalid_o), 32'(ok && i == done_idx));
            check_output("lsu_err", 32'(lsu_err_o), 32'(!ok && i == done_idx));
            check_output("lsu_stall", 32'(lsu_stall_o), 32'(i != done_idx));
            if (ok && i == done_idx)
                check_output("lsu_rdata", lsu_rdata_o, we ? 32'd0 : exp_load(t, a, mem));
            data_gnt_i    = legal && (i == g);
            data_rvalid_i = legal && (i == g + 1 + r);
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

        // Request held through the done cycle must not start a new access.
        if (hold) begin
            @(negedge clk_i);
            check_output("hold_no_req", 32'(data_req_o), 32'd0);
            check_output("hold_stall", 32'(lsu_stall_o), 32'd1);
            check_output("hold_no_pulse", 32'(lsu_rvalid_o | lsu_err_o), 32'd0);
        end
        lsu_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  t;
        logic [31:0] a;
        int          g, r;

        rst_i = 1'b1; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 3'd0;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        #3;
        check_output("reset_stall_follows_req", 32'(lsu_stall_o), 32'd1);
        check_output("reset_data_req", 32'(data_req_o), 32'd0);
        check_output("reset_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check_output("reset_err", 32'(lsu_err_o), 32'd0);
        check_output("reset_be", 32'(data_be_o), 32'd0);
        check_output("reset_rdata", lsu_rdata_o, 32'd0);
        lsu_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Directed scenarios.
        apply_stimulus(1'b0, 3'b000, 32'h0000_1000, 32'h0, 2, 0, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus(1'b0, 3'b010, 32'h0000_1003, 32'h0, 1, 1, 32'h8012_3456, 1'b0);
        apply_stimulus(1'b0, 3'b110, 32'h0000_1003, 32'h0, 0, 2, 32'h8012_3456, 1'b0);
        apply_stimulus(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 3'b000, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 3'b011, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 3'b001, 32'h0000_1002, 32'h0, 0, 0, 32'h7FFF_8001, 1'b1);

        // Randomized accesses, including slow grants/responses that time out.
        for (int n = 0; n < 60; n++) begin
            t = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) != 0 && t[1:0] == 2'b11) t[1:0] = 2'b10;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            g = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 5);
            r = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 5);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            apply_stimulus(1'($urandom_range(0, 1)), t, a, $urandom, g, r, $urandom,
                           1'($urandom_range(0, 1)));
        end

        // Grant never arrives: the short-timeout controller aborts after 4 cycles,
        // the main one after its own budget.
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 3'b000; lsu_addr_i = 32'h0000_3000;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        for (int i = 0; i <= MAIN_TO; i++) begin
            @(negedge clk_i);
            if (i <= SHORT_TO) begin
                check_output("t4_data_req", 32'(t4_req), 32'(i < SHORT_TO));
                check_output("t4_err", 32'(t4_err), 32'(i == SHORT_TO));
            end
            if (i == SHORT_TO) lsu_req_i = 1'b0;
            if (i >= SHORT_TO) begin
                check_output("main_timeout_err", 32'(lsu_err_o), 32'(i == MAIN_TO));
                check_output("main_timeout_req", 32'(data_req_o), 32'(i < MAIN_TO));
            end
        end

        // Reset while waiting for the response abandons the access silently.
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 3'b000; lsu_addr_i = 32'h0000_4000;
        @(negedge clk_i);
        check_output("rst_pre_req", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        check_output("rst_pre_wait_req", 32'(data_req_o), 32'd0);
        #2 rst_i = 1'b1;
        #1;
        check_output("rst_mid_data_req", 32'(data_req_o), 32'd0);
        check_output("rst_mid_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check_output("rst_mid_stall", 32'(lsu_stall_o), 32'd1);
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        check_output("post_rst_no_rvalid", 32'(lsu_rvalid_o), 32'd0);
        check_output("post_rst_no_err", 32'(lsu_err_o), 32'd0);
        @(negedge clk_i);
        check_output("post_rst_still_quiet", 32'(lsu_rvalid_o | lsu_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
